// File: rtl/img_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : img_op_scheduler
// Description : Runs a programmed subset of the mirror / gray / filter image
//               engines strictly in order. It grants the shared output-image
//               write port to the running engine only, and aborts the
//               sequence through a per-engine watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module img_op_scheduler #(
    parameter int TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op_mask,
    input  logic [2:0]  eng_done,
    input  logic [2:0]  eng_we,
    input  logic [17:0] eng_row,
    input  logic [17:0] eng_col,
    input  logic [71:0] eng_pix,
    output logic [2:0]  eng_start,
    output logic [5:0]  row,
    output logic [5:0]  col,
    output logic        out_we,
    output logic [23:0] out_pix,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  cur_op
);

    // Last watchdog value an engine may reach before it is declared hung.
    localparam logic [19:0] c_WDOG_LAST = 20'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_pend;
    logic [2:0]  w_pend_nxt;
    logic [1:0]  r_owner;
    logic [1:0]  w_owner_nxt;
    logic [19:0] r_wdog;
    logic [19:0] w_wdog_nxt;
    logic        r_error;
    logic        w_error_nxt;
    logic [2:0]  w_owner_vec;
    logic        w_owner_done;

    // Lowest pending engine, in +1 owner encoding (0 when nothing is left).
    function automatic logic [1:0] f_first_op(input logic [2:0] mask);
        if (mask[0]) begin
            return 2'd1;
        end else if (mask[1]) begin
            return 2'd2;
        end else if (mask[2]) begin
            return 2'd3;
        end else begin
            return 2'd0;
        end
    endfunction

    // One-hot view of the current owner, used for launch and done qualification.
    always_comb begin
        w_owner_vec = 3'b000;
        case (r_owner)
            2'd1:    w_owner_vec = 3'b001;
            2'd2:    w_owner_vec = 3'b010;
            2'd3:    w_owner_vec = 3'b100;
            default: w_owner_vec = 3'b000;
        endcase
    end

    // Only the owning engine's done is ever looked at.
    assign w_owner_done = |(eng_done & w_owner_vec);

    // State and sequencing registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pend  <= 3'b000;
            r_owner <= 2'd0;
            r_wdog  <= 20'd0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_owner <= w_owner_nxt;
            r_wdog  <= w_wdog_nxt;
            r_error <= w_error_nxt;
        end
    end

    // Next-state logic and control outputs. Ownership is handed over on the
    // way into LAUNCH so the port follows the engine from its launch cycle,
    // and is dropped on the way into GAP so the port idles for that cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_owner_nxt = r_owner;
        w_wdog_nxt  = r_wdog;
        w_error_nxt = r_error;
        eng_start   = 3'b000;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_error_nxt = 1'b0;
                    if (op_mask != 3'b000) begin
                        w_pend_nxt  = op_mask;
                        w_owner_nxt = f_first_op(op_mask);
                        w_state_nxt = S_LAUNCH;
                    end else begin
                        w_state_nxt = S_FINISH;
                    end
                end
            end
            S_LAUNCH: begin
                eng_start   = w_owner_vec;
                w_wdog_nxt  = 20'd0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_wdog_nxt = r_wdog + 20'd1;
                if (w_owner_done) begin
                    w_pend_nxt  = r_pend & ~w_owner_vec;
                    w_owner_nxt = 2'd0;
                    w_state_nxt = S_GAP;
                end else if (r_wdog == c_WDOG_LAST) begin
                    w_error_nxt = 1'b1;
                    w_pend_nxt  = 3'b000;
                    w_owner_nxt = 2'd0;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                w_owner_nxt = 2'd0;
                if (r_pend != 3'b000) begin
                    w_owner_nxt = f_first_op(r_pend);
                    w_state_nxt = S_LAUNCH;
                end else begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Zero-latency write-port mux; an unowned port is held at all zeros.
    always_comb begin
        row     = 6'd0;
        col     = 6'd0;
        out_pix = 24'd0;
        out_we  = 1'b0;
        case (r_owner)
            2'd1: begin
                row     = eng_row[5:0];
                col     = eng_col[5:0];
                out_pix = eng_pix[23:0];
                out_we  = eng_we[0];
            end
            2'd2: begin
                row     = eng_row[11:6];
                col     = eng_col[11:6];
                out_pix = eng_pix[47:24];
                out_we  = eng_we[1];
            end
            2'd3: begin
                row     = eng_row[17:12];
                col     = eng_col[17:12];
                out_pix = eng_pix[71:48];
                out_we  = eng_we[2];
            end
            default: begin
                row     = 6'd0;
                col     = 6'd0;
                out_pix = 24'd0;
                out_we  = 1'b0;
            end
        endcase
    end

    assign busy   = (r_state != S_IDLE);
    assign error  = r_error;
    assign cur_op = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_img_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_img_op_scheduler
// Description : Self-checking bench for img_op_scheduler. A sequence-level
//               timeline model predicts launches, ownership, busy/done/error
//               per cycle; engines are modelled as fixed-latency responders.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_img_op_scheduler;

    localparam int TO   = 12;
    localparam int MAXC = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op_mask;
    logic [2:0]  eng_done;
    logic [2:0]  eng_we;
    logic [17:0] eng_row;
    logic [17:0] eng_col;
    logic [71:0] eng_pix;
    logic [2:0]  eng_start;
    logic [5:0]  row;
    logic [5:0]  col;
    logic        out_we;
    logic [23:0] out_pix;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  cur_op;

    int n_vec = 0;
    int n_bad = 0;

    img_op_scheduler #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .op_mask(op_mask),
        .eng_done(eng_done), .eng_we(eng_we), .eng_row(eng_row),
        .eng_col(eng_col), .eng_pix(eng_pix), .eng_start(eng_start),
        .row(row), .col(col), .out_we(out_we), .out_pix(out_pix),
        .busy(busy), .done(done), .error(error), .cur_op(cur_op)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mask;
        int         d0;
        int         d1;
        int         d2;
        int         exp_fin;
        logic       exp_err;
        int         exp_starts;
    } vec_t;

    // Per-cycle expectations for the scenario in flight.
    int         exp_own  [MAXC];
    logic [2:0] exp_st   [MAXC];
    logic       exp_busy [MAXC];
    logic       exp_dn   [MAXC];
    logic       exp_er   [MAXC];
    logic       model_err = 1'b0;
    int         obs_done_cyc;
    int         obs_starts;
    logic       obs_err_end;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // What the shared port must show when engine 'own' (1..3) holds it.
    function automatic logic [36:0] exp_port(input int own);
        int k;
        if (own == 0) return 37'd0;
        k = own - 1;
        return {eng_we[k], eng_row[k*6 +: 6], eng_col[k*6 +: 6], eng_pix[k*24 +: 24]};
    endfunction

    task automatic rand_eng_data();
        eng_we  = 3'($urandom);
        eng_row = 18'($urandom);
        eng_col = 18'($urandom);
        eng_pix = 72'({$urandom, $urandom, $urandom});
    endtask

    task automatic zero_inputs();
        start    = 1'b0;
        op_mask  = 3'b000;
        eng_done = 3'b000;
        eng_we   = 3'b000;
        eng_row  = 18'd0;
        eng_col  = 18'd0;
        eng_pix  = 72'd0;
    endtask

    // One sequence: d[k] is engine k's done latency after its launch cycle
    // (0 = never answers). Engines react to the DUT's actual eng_start.
    task automatic run_scn(input logic [2:0] mask, input int d0, input int d1,
                           input int d2, input logic noise);
        int   d [3];
        int   launch [3];
        int   t, last, gap, errfrom, fin;
        logic abort;
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int c = 0; c < MAXC; c++) begin
            exp_own[c] = 0; exp_st[c] = 3'b000; exp_busy[c] = 1'b0;
            exp_dn[c] = 1'b0; exp_er[c] = 1'b0;
        end
        exp_er[0] = model_err;
        errfrom = MAXC;
        abort = 1'b0;
        t = 1;
        gap = 0;
        for (int k = 0; k < 3; k++) begin
            if (mask[k] && !abort) begin
                exp_st[t] = 3'(1 << k);
                if (d[k] != 0 && d[k] <= TO) begin
                    last = t + d[k];
                end else begin
                    last = t + TO;
                    abort = 1'b1;
                end
                for (int c = t; c <= last; c++) exp_own[c] = k + 1;
                gap = last + 1;
                if (abort) errfrom = gap;
                t = gap + 1;
            end
        end
        fin = t;
        for (int c = 1; c <= fin; c++) exp_busy[c] = 1'b1;
        exp_dn[fin] = 1'b1;
        for (int c = errfrom; c < MAXC; c++) exp_er[c] = 1'b1;

        launch[0] = -1; launch[1] = -1; launch[2] = -1;
        obs_done_cyc = -1;
        obs_starts = 0;
        obs_err_end = 1'b0;
        for (int c = 0; c <= fin + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start   = 1'b1;
                op_mask = mask;
            end else begin
                start   = exp_busy[c] ? 1'($urandom_range(0, 1)) : 1'b0;
                op_mask = 3'($urandom);
            end
            rand_eng_data();
            eng_done = 3'b000;
            for (int k = 0; k < 3; k++) begin
                if (launch[k] >= 0 && d[k] != 0 && c == launch[k] + d[k])
                    eng_done[k] = 1'b1;
                else if (noise && exp_own[c] != k + 1 && $urandom_range(0, 3) == 0)
                    eng_done[k] = 1'b1;
            end
            #1;
            chk($sformatf("ctrl[c%0d]{eng_start,busy,done,error,cur_op}", c),
                64'({eng_start, busy, done, error, cur_op}),
                64'({exp_st[c], exp_busy[c], exp_dn[c], exp_er[c], 2'(exp_own[c])}));
            chk($sformatf("port[c%0d]{we,row,col,pix}", c),
                64'({out_we, row, col, out_pix}), 64'(exp_port(exp_own[c])));
            for (int k = 0; k < 3; k++) if (eng_start[k]) launch[k] = c;
            obs_starts += $countones(eng_start);
            if (done && obs_done_cyc < 0) obs_done_cyc = c;
            obs_err_end = error;
        end
        model_err = exp_er[fin + 1];
        start = 1'b0;
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = '{3'b111, 10, 10, 10, 37, 1'b0, 3};
        tbl[1] = '{3'b100,  0,  0,  5,  8, 1'b0, 1};
        tbl[2] = '{3'b000,  0,  0,  0,  1, 1'b0, 0};
        tbl[3] = '{3'b011,  4,  0,  3, 21, 1'b1, 2};
        tbl[4] = '{3'b101, 12,  0, 13, 29, 1'b1, 2};
        tbl[5] = '{3'b010,  0,  1,  0,  4, 1'b0, 1};
        tbl[6] = '{3'b110,  0,  2,  1,  8, 1'b0, 2};

        // Reset state.
        zero_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rand_eng_data();
        #1;
        chk("reset_state", 64'({eng_start, busy, done, error, cur_op, out_we, row, col, out_pix}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        zero_inputs();

        // Table-driven sequences.
        for (int i = 0; i < 7; i++) begin
            run_scn(tbl[i].mask, tbl[i].d0, tbl[i].d1, tbl[i].d2, 1'b1);
            chk($sformatf("tbl%0d_done_cycle", i), 64'(obs_done_cyc), 64'(tbl[i].exp_fin));
            chk($sformatf("tbl%0d_error", i), 64'(obs_err_end), 64'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_launches", i), 64'(obs_starts), 64'(tbl[i].exp_starts));
        end

        // Ownership isolation while mirror owns the port.
        @(negedge clk); zero_inputs(); start = 1'b1; op_mask = 3'b001; #1;
        @(negedge clk); start = 1'b0; #1;
        chk("iso_launch{eng_start,cur_op}", 64'({eng_start, cur_op}), 64'({3'b001, 2'd1}));
        @(negedge clk);
        eng_row  = {6'd63, 6'd0, 6'd5};
        eng_col  = {6'd1, 6'd2, 6'd9};
        eng_pix  = {24'hAAAAAA, 24'hBBBBBB, 24'h112233};
        eng_we   = 3'b101;
        eng_done = 3'b110;
        #1;
        chk("iso_port{we,row,col,pix}", 64'({out_we, row, col, out_pix}),
            64'({1'b1, 6'd5, 6'd9, 24'h112233}));
        @(negedge clk); eng_done = 3'b000; #1;
        chk("iso_nonowner_done{busy,cur_op,done}", 64'({busy, cur_op, done}), 64'({1'b1, 2'd1, 1'b0}));
        @(negedge clk); eng_done = 3'b001; #1;
        @(negedge clk); eng_done = 3'b000; eng_we = 3'b111; #1;
        chk("iso_gap{out_we,cur_op,busy,done}", 64'({out_we, cur_op, busy, done}), 64'({1'b0, 2'd0, 1'b1, 1'b0}));
        @(negedge clk); #1;
        chk("iso_finish{done,busy}", 64'({done, busy}), 64'({1'b1, 1'b1}));
        @(negedge clk); #1;
        chk("iso_idle{done,busy}", 64'({done, busy}), 64'({1'b0, 1'b0}));
        model_err = 1'b0;

        // Reset in the middle of RUN; starts while busy are ignored.
        @(negedge clk); zero_inputs(); start = 1'b1; op_mask = 3'b111; #1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); start = 1'b1; op_mask = 3'b000; #1;
            chk($sformatf("rst_pre_busy[c%0d]{busy,done}", c), 64'({busy, done}), 64'({1'b1, 1'b0}));
        end
        @(negedge clk); start = 1'b0; eng_we = 3'b111; rst = 1'b1; #1;
        chk("rst_pre_owner", 64'(cur_op), 64'd1);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_after{busy,cur_op,out_we,done,eng_start,error}",
            64'({busy, cur_op, out_we, done, eng_start, error}), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("rst_quiet[%0d]{busy,done,eng_start}", c),
                64'({busy, done, eng_start}), 64'd0);
        end
        model_err = 1'b0;
        run_scn(3'b001, 3, 0, 0, 1'b0);
        chk("rst_fresh_done_cycle", 64'(obs_done_cyc), 64'd6);

        // Randomized sequences against the timeline model.
        for (int i = 0; i < 30; i++) begin
            logic [2:0] m;
            int dd [3];
            m = 3'($urandom);
            for (int k = 0; k < 3; k++)
                dd[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TO + 2));
            run_scn(m, dd[0], dd[1], dd[2], 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL global_timeout: got still running, expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
